// File: rtl/pte_mem_responder.sv
// PTE memory responder between the MMU page walker and the DRAM arbiter PTE port.
// One request at a time, single-request DRAM handshake, one-entry PTE buffer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a walker request
//   REQ   | DRAM request presented, waiting for i_dram_ack
//   RWAIT | read accepted by DRAM, waiting for i_dram_rvalid
//   DONE  | completion cycle (o_done=1); a buffer hit spends one extra
//         | busy cycle here first so hit and miss share the same latency floor
module pte_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit BUF_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_flush,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_dram_req,
    output logic              o_dram_we,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic [DATA_W-1:0] o_dram_wdata,
    input  logic              i_dram_ack,
    input  logic              i_dram_rvalid,
    input  logic [DATA_W-1:0] i_dram_rdata
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic                we_q;
    logic [WA_W-1:0]     addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                hit_wait_q;
    logic                flushed_q;

    logic                buf_valid_q;
    logic [WA_W-1:0]     buf_addr_q;
    logic [DATA_W-1:0]   buf_data_q;

    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                dram_req_q;
    logic                dram_we_q;
    logic [ADDR_W-1:0]   dram_addr_q;
    logic [DATA_W-1:0]   dram_wdata_q;

    logic [WA_W-1:0]     req_word;
    logic                buf_hit;
    logic                install_ok;
    logic                unused_addr_lsb;

    assign req_word        = i_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^i_addr[1:0];

    // A flush arriving with the request wins over a hit.
    assign buf_hit    = BUF_EN && buf_valid_q && !i_flush && (buf_addr_q == req_word);
    // Data from a transaction that saw a flush while in flight is stale to the buffer.
    assign install_ok = BUF_EN && !flushed_q && !i_flush;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hit_wait_q   <= 1'b0;
            flushed_q    <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (i_flush) begin
                buf_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        we_q      <= i_we;
                        addr_q    <= req_word;
                        wdata_q   <= i_wdata;
                        flushed_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (!i_we && buf_hit) begin
                            rdata_q    <= buf_data_q;
                            hit_wait_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            dram_req_q   <= 1'b1;
                            dram_we_q    <= i_we;
                            dram_addr_q  <= {req_word, 2'b00};
                            dram_wdata_q <= i_wdata;
                            state_q      <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (i_flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (i_dram_ack) begin
                        dram_req_q   <= 1'b0;
                        dram_we_q    <= 1'b0;
                        dram_addr_q  <= '0;
                        dram_wdata_q <= '0;
                        if (we_q) begin
                            if (install_ok) begin
                                buf_valid_q <= 1'b1;
                                buf_addr_q  <= addr_q;
                                buf_data_q  <= wdata_q;
                            end
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (i_dram_rvalid) begin
                            rdata_q <= i_dram_rdata;
                            if (install_ok) begin
                                buf_valid_q <= 1'b1;
                                buf_addr_q  <= addr_q;
                                buf_data_q  <= i_dram_rdata;
                            end
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RWAIT;
                        end
                    end
                end

                RWAIT: begin
                    if (i_flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (i_dram_rvalid) begin
                        rdata_q <= i_dram_rdata;
                        if (install_ok) begin
                            buf_valid_q <= 1'b1;
                            buf_addr_q  <= addr_q;
                            buf_data_q  <= i_dram_rdata;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    if (hit_wait_q) begin
                        hit_wait_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_rdata      = rdata_q;
    assign o_dram_req   = dram_req_q;
    assign o_dram_we    = dram_we_q;
    assign o_dram_addr  = dram_addr_q;
    assign o_dram_wdata = dram_wdata_q;

endmodule

// File: tb/tb_pte_mem_responder.sv
// Scoreboard bench for pte_mem_responder: a transaction-level model predicts each
// completion; a negedge monitor checks DRAM requests and completions against the queue.
module tb_pte_mem_responder;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        i_req, i_we, i_flush;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_dram_req, o_dram_we;
    logic [31:0] o_rdata, o_dram_addr, o_dram_wdata;
    logic        i_dram_ack, i_dram_rvalid;
    logic [31:0] i_dram_rdata;

    pte_mem_responder #(.ADDR_W(32), .DATA_W(32), .BUF_EN(1'b1)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_flush(i_flush),
        .o_busy(o_busy), .o_rdata(o_rdata), .o_done(o_done),
        .o_dram_req(o_dram_req), .o_dram_we(o_dram_we), .o_dram_addr(o_dram_addr),
        .o_dram_wdata(o_dram_wdata),
        .i_dram_ack(i_dram_ack), .i_dram_rvalid(i_dram_rvalid), .i_dram_rdata(i_dram_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          miss;
        int          lat;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: buffer contents and last read value.
    bit          m_valid = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST_X = 1'b0;
        i_req = 0; i_we = 0; i_flush = 0; i_dram_ack = 0; i_dram_rvalid = 0;
        exp_q.delete();
        m_valid = 1'b0;
        m_rdata = '0;
        repeat (2) tick();
        RST_X = 1'b1;
        tick();
    endtask

    // Monitor: DRAM request contents every cycle, completions against the scoreboard.
    bit   seen_dram = 1'b0;
    exp_t e_mon;
    always @(negedge CLK) begin
        if (!RST_X) begin
            seen_dram = 1'b0;
        end else begin
            if (o_dram_req) begin
                seen_dram = 1'b1;
                if (exp_q.size() == 0) fail("dram_req_unexpected");
                else begin
                    chk("dram_addr", o_dram_addr, exp_q[0].addr);
                    chk("dram_we", 32'(o_dram_we), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("dram_wdata", o_dram_wdata, exp_q[0].wdata);
                end
            end
            if (o_done) begin
                if (exp_q.size() == 0) fail("done_unexpected");
                else begin
                    e_mon = exp_q.pop_front();
                    chk("rdata", o_rdata, e_mon.rdata);
                    chk("dram_traffic", 32'(seen_dram), 32'(e_mon.miss));
                    chk("busy_at_done", 32'(o_busy), 32'd0);
                    chk("latency", 32'(cyc - e_mon.issue), 32'(e_mon.lat));
                end
                seen_dram = 1'b0;
            end
        end
    end

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (!o_done && n < 12) begin
            tick();
            n++;
        end
        ok = o_done;
        if (!ok) begin
            fail("done_timeout");
            apply_reset();
        end
    endtask

    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rret, input int a, input int r,
                          input bit flush_req, input bit flush_rw_in);
        exp_t e;
        bit   hit, flush_rw, ok;
        int   n;
        hit = !we && !flush_req && m_valid && (m_addr == addr[31:2]);
        flush_rw = flush_rw_in && !we && !hit && (r > 0);
        if (flush_req) m_valid = 1'b0;
        e.we    = we;
        e.addr  = {addr[31:2], 2'b00};
        e.wdata = wdata;
        e.rdata = we ? m_rdata : (hit ? m_data : rret);
        e.miss  = !hit;
        e.lat   = hit ? 2 : (2 + a + (we ? 0 : r));
        if (!we) m_rdata = e.rdata;
        if (!hit) begin
            if (flush_rw) m_valid = 1'b0;
            else begin
                m_valid = 1'b1;
                m_addr  = addr[31:2];
                m_data  = we ? wdata : rret;
            end
        end

        i_req = 1; i_we = we; i_addr = addr; i_wdata = wdata; i_flush = flush_req;
        e.issue = cyc;
        exp_q.push_back(e);
        tick();
        i_req = 0; i_flush = 0;
        chk("busy_after_req", 32'(o_busy), 32'd1);

        if (!hit) begin
            n = 0;
            while (!o_dram_req && n < 8) begin
                tick();
                n++;
            end
            if (!o_dram_req) begin
                fail("dram_req_timeout");
                apply_reset();
                return;
            end
            repeat (a) begin
                // Ignored traffic while busy: new requests and stray read data.
                i_req = 1'($urandom_range(0, 1));
                i_we = 1'($urandom_range(0, 1));
                i_addr = $urandom;
                i_dram_rvalid = 1'($urandom_range(0, 1));
                i_dram_rdata = $urandom;
                tick();
            end
            i_req = 0;
            i_dram_ack = 1;
            i_dram_rvalid = we ? 1'($urandom_range(0, 1)) : (r == 0);
            i_dram_rdata = (!we && r == 0) ? rret : $urandom;
            tick();
            i_dram_ack = 0;
            i_dram_rvalid = 0;
            if (!we && r > 0) begin
                for (int j = 1; j <= r; j++) begin
                    i_flush = flush_rw && (j == 1);
                    i_dram_rvalid = (j == r);
                    i_dram_rdata = (j == r) ? rret : $urandom;
                    tick();
                    i_flush = 0;
                    i_dram_rvalid = 0;
                end
            end
        end
        wait_done(ok);
        if (!ok) return;
        i_req = 0;
        tick();
        if ($urandom_range(0, 9) == 0) begin
            i_flush = 1;
            m_valid = 1'b0;
            tick();
            i_flush = 0;
        end
    endtask

    logic [31:0] pool [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0; i_flush = 0;
        i_dram_ack = 0; i_dram_rvalid = 0; i_dram_rdata = 0;
        RST_X = 0;
        #2;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_dram_req", 32'(o_dram_req), 32'd0);
        chk("rst_dram_addr", o_dram_addr, 32'd0);
        repeat (2) tick();
        RST_X = 1;
        tick();

        // Directed scenarios.
        do_txn(0, 32'h8000_1004, 32'h0, 32'h2000_0C01, 2, 3, 0, 0);
        do_txn(0, 32'h8000_1007, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_txn(1, 32'h8000_1004, 32'h2000_0CC1, 32'h0, 1, 0, 0, 0);
        do_txn(0, 32'h8000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_txn(0, 32'h8000_2000, 32'h0, 32'h1234_5001, 0, 2, 0, 1);
        do_txn(0, 32'h8000_2000, 32'h0, 32'h1234_5001, 1, 1, 0, 0);
        do_txn(0, 32'h8000_3000, 32'h0, 32'hA5A5_0001, 0, 0, 0, 0);
        do_txn(0, 32'h8000_3002, 32'h0, 32'h5A5A_0003, 0, 0, 1, 0);

        // Reset while a read sits in RWAIT.
        begin
            exp_t e;
            e.we = 0; e.addr = 32'h8000_5000; e.wdata = 0; e.rdata = 32'h0;
            e.miss = 1; e.lat = 0;
            i_req = 1; i_we = 0; i_addr = 32'h8000_5000;
            e.issue = cyc;
            exp_q.push_back(e);
            tick();
            i_req = 0;
            i_dram_ack = 1;
            tick();
            i_dram_ack = 0;
            chk("dram_req_drop_after_ack", 32'(o_dram_req), 32'd0);
            #2;
            RST_X = 0;
            #1;
            chk("midrst_busy", 32'(o_busy), 32'd0);
            chk("midrst_done", 32'(o_done), 32'd0);
            chk("midrst_rdata", o_rdata, 32'd0);
            chk("midrst_dram", {o_dram_req, o_dram_we, o_dram_addr[29:0]}, 32'd0);
            exp_q.delete();
            m_valid = 1'b0;
            m_rdata = '0;
            repeat (2) tick();
            RST_X = 1;
            i_dram_rvalid = 1;
            i_dram_rdata = 32'hFFFF_FFFF;
            tick();
            i_dram_rvalid = 0;
            repeat (3) tick();
            chk("no_done_after_reset", 32'(o_done), 32'd0);
            chk("rdata_after_reset", o_rdata, 32'd0);
            do_txn(0, 32'h8000_5000, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 0);
        end

        // Randomized traffic over a small address pool so hits are frequent.
        pool[0] = 32'h8000_1000; pool[1] = 32'h8000_1004;
        pool[2] = 32'h8000_2000; pool[3] = 32'h8000_4FF8;
        for (int k = 0; k < 200; k++) begin
            logic [31:0] ad;
            ad = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            do_txn($urandom_range(0, 9) < 3, ad, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        repeat (3) tick();
        if (exp_q.size() != 0) fail("scoreboard_not_empty");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
